// File: rtl/spss_pkg.sv
// spss_pkg: shared state encoding, error bit positions, latency bounds and request record
package spss_pkg;
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACCESS  = 2'd1;
   localparam logic [1:0] ST_RESPOND = 2'd2;
   localparam logic [1:0] ST_DRAIN   = 2'd3;
   localparam int ERR_ADDR = 0;
   localparam int ERR_OVF  = 1;
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 15;
   typedef struct packed {
      logic        valid;
      logic        wr;
      logic [63:0] addr;
   } req_t;
   localparam req_t REQ_NONE = '0;
endpackage

// File: rtl/scratchpad_stream_server_if.sv
// scratchpad_stream_server_if: kernel-side request/response bus of the scratchpad server
interface scratchpad_stream_server_if #(parameter int DATA_WID = 32);
   logic                read_enable;
   logic [63:0]         read_addr;
   logic                write_enable;
   logic [63:0]         write_addr;
   logic [DATA_WID-1:0] write_data;
   logic [63:0]         read_ready;
   logic [63:0]         write_ready;
   logic [DATA_WID-1:0] read_data;
   modport master (
      output read_enable, read_addr, write_enable, write_addr, write_data,
      input  read_ready, write_ready, read_data
   );
   modport slave (
      input  read_enable, read_addr, write_enable, write_addr, write_data,
      output read_ready, write_ready, read_data
   );
endinterface

// File: rtl/spss_ram.sv
// spss_ram: single-port synchronous scratchpad with one-cycle registered read, contents never reset
module spss_ram #(
   parameter int ADDR_WID = 14,
   parameter int DATA_WID = 32
) (
   input  logic                clk,
   input  logic                en,
   input  logic                we,
   input  logic [ADDR_WID-1:0] addr,
   input  logic [DATA_WID-1:0] wdata,
   output logic [DATA_WID-1:0] rdata
);
   logic [DATA_WID-1:0] mem [2**ADDR_WID];
   always_ff @(posedge clk)
      if (en) begin
         if (we) mem[addr] <= wdata;
         else rdata <= mem[addr];
      end
endmodule

// File: rtl/scratchpad_stream_server.sv
// scratchpad_stream_server: fixed-latency read/write server over a word scratchpad with one pending slot
module scratchpad_stream_server
   import spss_pkg::*;
#(
   parameter int ADDR_WID = 14,
   parameter int DATA_WID = 32,
   parameter int LATENCY  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] read_base,
   input  logic [63:0] write_base,
   input  logic        done,
   scratchpad_stream_server_if.slave bus,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count,
   output logic [1:0]  err,
   output logic        finished
);
   localparam int LAT = LATENCY < LAT_MIN ? LAT_MIN : LATENCY > LAT_MAX ? LAT_MAX : LATENCY;
   localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);
   logic [1:0]          state;
   logic [3:0]          cnt;
   req_t                cur, pend, w_req, r_req, head, tail;
   logic [DATA_WID-1:0] cur_data, pend_data, head_data, rd_data_q, ram_rdata;
   logic                done_seen, resp_fault, rd_pulse, wr_pulse, free, ovf, fault, ram_en;
   logic [63:0]         base, widx;
   assign w_req = {bus.write_enable && state != ST_DRAIN, 1'b1, bus.write_addr};
   assign r_req = {bus.read_enable && state != ST_DRAIN, 1'b0, bus.read_addr};
   assign free  = state == ST_IDLE || state == ST_RESPOND;
   // candidates in priority order: pending slot (when free), write strobe, read strobe
   assign head      = free && pend.valid ? pend : w_req.valid ? w_req : r_req;
   assign head_data = free && pend.valid ? pend_data : bus.write_data;
   assign tail      = free && pend.valid ? (w_req.valid ? w_req : r_req) : (w_req.valid ? r_req : REQ_NONE);
   assign ovf = free ? pend.valid && w_req.valid && r_req.valid
                     : state == ST_ACCESS && (pend.valid ? head.valid : tail.valid);
   assign base   = cur.wr ? write_base : read_base;
   assign widx   = (cur.addr - base) >> 2;
   assign fault  = cur.addr < base || |cur.addr[1:0] || |(widx >> ADDR_WID);
   assign ram_en = state == ST_ACCESS && cnt == 4'd0 && !fault;
   spss_ram #(.ADDR_WID(ADDR_WID), .DATA_WID(DATA_WID)) u_ram (
      .clk  (clk),
      .en   (ram_en),
      .we   (cur.wr),
      .addr (widx[ADDR_WID-1:0]),
      .wdata(cur_data),
      .rdata(ram_rdata)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         cur        <= REQ_NONE;
         pend       <= REQ_NONE;
         cur_data   <= '0;
         pend_data  <= '0;
         done_seen  <= 1'b0;
         resp_fault <= 1'b0;
         rd_pulse   <= 1'b0;
         wr_pulse   <= 1'b0;
         rd_data_q  <= '0;
         rd_count   <= '0;
         wr_count   <= '0;
         err        <= '0;
      end else begin
         rd_pulse  <= state == ST_RESPOND && !cur.wr;
         wr_pulse  <= state == ST_RESPOND && cur.wr;
         done_seen <= done_seen | done;
         if (ovf) err[ERR_OVF] <= 1'b1;
         if (state == ST_RESPOND) begin
            if (cur.wr) wr_count <= wr_count + 32'd1;
            else begin
               rd_count  <= rd_count + 32'd1;
               rd_data_q <= resp_fault ? '0 : ram_rdata;
            end
         end
         if (free) begin
            cur       <= head;
            cur_data  <= head_data;
            pend      <= tail;
            pend_data <= bus.write_data;
            cnt       <= CNT_LOAD;
            state     <= head.valid ? ST_ACCESS : done_seen || done ? ST_DRAIN : ST_IDLE;
         end else if (state == ST_ACCESS) begin
            if (!pend.valid) begin
               pend      <= head;
               pend_data <= bus.write_data;
            end
            cnt <= cnt - 4'd1;
            if (cnt == 4'd0) begin
               resp_fault <= fault;
               state      <= ST_RESPOND;
               if (fault) err[ERR_ADDR] <= 1'b1;
            end
         end
      end
   assign bus.read_ready  = 64'(rd_pulse);
   assign bus.write_ready = 64'(wr_pulse);
   assign bus.read_data   = rd_data_q;
   assign finished        = state == ST_DRAIN;
endmodule

// File: doc/scratchpad_stream_server.md
SCRATCHPAD_STREAM_SERVER -- requirements
Module: scratchpad_stream_server

Interface
REQ-001 SHALL have parameter ADDR_WID, default 14, meaning scratchpad word-index width (16384 words).
REQ-002 SHALL have parameter DATA_WID, default 32, meaning scratchpad word width.
REQ-003 SHALL have parameter LATENCY, default 4, range 1..15, meaning cycles from request acceptance to ready pulse.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port read_base, input, 64, meaning byte base address of the read window.
REQ-007 SHALL have port write_base, input, 64, meaning byte base address of the write window.
REQ-008 SHALL have port read_enable, input, 1, meaning one-cycle read request strobe from the kernel.
REQ-009 SHALL have port read_addr, input, 64, meaning byte address of the read.
REQ-010 SHALL have port write_enable, input, 1, meaning one-cycle write request strobe.
REQ-011 SHALL have port write_addr, input, 64, meaning byte address of the write.
REQ-012 SHALL have port write_data, input, 32, meaning write payload.
REQ-013 SHALL have port done, input, 1, meaning kernel completion pulse.
REQ-014 SHALL have port read_ready, output, 64, meaning value 1 for one cycle when read_data is valid, else 0.
REQ-015 SHALL have port write_ready, output, 64, meaning value 1 for one cycle when a write is committed, else 0.
REQ-016 SHALL have port read_data, output, 32, meaning read result, held until the next read response.
REQ-017 SHALL have port rd_count and wr_count, outputs, 32 each, meaning serviced read/write totals.
REQ-018 SHALL have port err, output, 2, meaning sticky flags: bit0 address fault, bit1 request overflow.
REQ-019 SHALL have port finished, output, 1, meaning sticky: done seen and no request outstanding.

Function
REQ-020 SHALL compute word index = (addr - base) >> 2, truncated to ADDR_WID bits after range check.
REQ-021 SHALL flag address fault when addr < base, addr[1:0] != 0, or index >= 2^ADDR_WID; a faulting read returns 0, a faulting write is dropped; ready is still pulsed.
REQ-022 SHALL run FSM states IDLE, ACCESS, RESPOND, DRAIN.
REQ-023 IDLE: on a strobe, latch request, load counter with LATENCY-1, go ACCESS; stays IDLE otherwise.
REQ-024 ACCESS: decrement counter; at 0 perform the RAM access and go RESPOND.
REQ-025 RESPOND: pulse the matching ready for exactly one cycle, update read_data/counts, then take the pending slot (to ACCESS) or go IDLE.
REQ-026 SHALL give total latency of exactly LATENCY+1 cycles from the strobe edge to the ready-high cycle.
REQ-027 SHALL, on simultaneous read_enable and write_enable, service the write first and put the read in the pending slot.
REQ-028 SHALL capture a strobe arriving outside IDLE into a one-entry pending slot; if the slot is full, drop it and set err[1].
REQ-029 SHALL never assert read_ready and write_ready in the same cycle.
REQ-030 SHALL, on done, go to DRAIN after outstanding work; DRAIN sets finished and ignores further strobes.
REQ-031 SHALL let rd_count/wr_count wrap modulo 2^32.

Reset
REQ-032 SHALL, while reset is 0, immediately force state IDLE, ready outputs 0, read_data 0, counts 0, err 0, finished 0, pending slot empty.
REQ-033 SHALL discard an in-flight request on reset mid-operation, with no ready pulse after release.
REQ-034 SHALL not reset scratchpad contents.

Structure
REQ-035 SHALL put the state encoding, the err bit positions and the LATENCY bounds in a shared package spss_pkg.
REQ-036 SHALL put the storage in one sub-module spss_ram: single-port, synchronous, 1-cycle read.

Verification
REQ-037 Reset release, write 0xDEADBEEF at write_base+8 -> write_ready=1 exactly 5 cycles later (LATENCY=4); wr_count=1.
REQ-038 Read read_base+8 with read_base=write_base -> read_ready after 5 cycles; read_data=0xDEADBEEF; rd_count=1.
REQ-039 Simultaneous read and write strobes -> write_ready first, then read_ready; never both high at once; err=0.
REQ-040 Read at read_base+2 and read at read_base-4 -> ready pulses still occur; read_data=0; err[0]=1.
REQ-041 Three strobes back-to-back while busy -> two serviced, third dropped; err[1]=1.
REQ-042 reset low during ACCESS -> no ready pulse after release; counts 0; finished=0; then done -> finished=1.
